// File: rtl/xtimer_prog.sv
// xtimer_prog: programmable down-counting timer with prescaler,
// one-shot / auto-reload modes, sticky expiry flag and expiry pulse.
module xtimer_prog #(
    parameter int WIDTH   = 20,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               mode,
    input  logic [WIDTH-1:0]   period,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               running,
    output logic               tc,
    output logic               tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic               tc_q, tc_d;
    logic               tick_q, tick_d;

    // Next-state logic: start overrides everything, then stop, then counting.
    // tc set by an expiry beats a same-cycle clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        tc_d    = tc_q;
        tick_d  = 1'b0;
        if (start) begin
            state_d = S_RUN;
            cnt_d   = period;
            pcnt_d  = presc;
            tc_d    = 1'b0;
        end else begin
            if (clear) begin
                tc_d = 1'b0;
            end
            case (state_q)
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - PRESC_W'(1);
                    end else if (cnt_q != '0) begin
                        pcnt_d = presc;
                        cnt_d  = cnt_q - WIDTH'(1);
                    end else begin
                        tick_d = 1'b1;
                        tc_d   = 1'b1;
                        if (mode) begin
                            cnt_d  = period;
                            pcnt_d = presc;
                        end else begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
                    end
                end
                S_DONE: begin
                    cnt_d = '0;
                    if (clear) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            tc_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            tc_q    <= tc_d;
            tick_q  <= tick_d;
        end
    end

    assign count   = cnt_q;
    assign running = (state_q == S_RUN);
    assign tc      = tc_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_xtimer_prog.sv
// tb_xtimer_prog: table-driven vectors plus hand sequences for
// prescaled periodic mode, stop/restart and full-range one-shot.
module tb_xtimer_prog;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst, start, stop, clear, mode;
    logic [W-1:0]  period;
    logic [PW-1:0] presc;
    logic [W-1:0]  count;
    logic          running, tc, tick;

    int nvec = 0;
    int nerr = 0;

    xtimer_prog #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .mode    (mode),
        .period  (period),
        .presc   (presc),
        .count   (count),
        .running (running),
        .tc      (tc),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          rst, start, stop, clear, mode;
        logic [W-1:0]  period;
        logic [PW-1:0] presc;
        logic [W-1:0]  e_count;
        logic          e_run, e_tc, e_tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input string nm, input logic r, input logic s,
        input logic sp, input logic c, input logic m,
        input logic [W-1:0] p, input logic [PW-1:0] q,
        input logic [W-1:0] ec, input logic er,
        input logic et, input logic ek);
        vec_t v;
        v.name = nm; v.rst = r; v.start = s; v.stop = sp;
        v.clear = c; v.mode = m; v.period = p; v.presc = q;
        v.e_count = ec; v.e_run = er; v.e_tc = et; v.e_tick = ek;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic sp,
                         input logic c, input logic m,
                         input logic [W-1:0] p, input logic [PW-1:0] q);
        rst = r; start = s; stop = sp; clear = c;
        mode = m; period = p; presc = q;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int extra;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        //            name       r  s  sp c  m  P  Q  cnt run tc tick
        tbl.push_back(mk("reset",   1,0,0,0,0, 0,0, 0,0,0,0));
        tbl.push_back(mk("os_e0",   0,1,0,0,0, 3,0, 3,1,0,0));
        tbl.push_back(mk("os_e1",   0,0,0,0,0, 3,0, 2,1,0,0));
        tbl.push_back(mk("os_e2",   0,0,0,0,0, 3,0, 1,1,0,0));
        tbl.push_back(mk("os_e3",   0,0,0,0,0, 3,0, 0,1,0,0));
        tbl.push_back(mk("os_exp",  0,0,0,0,0, 3,0, 0,0,1,1));
        tbl.push_back(mk("os_done", 0,0,0,0,0, 3,0, 0,0,1,0));
        tbl.push_back(mk("os_clr",  0,0,0,1,0, 3,0, 0,0,0,0));
        tbl.push_back(mk("cc_e0",   0,1,0,0,1, 1,0, 1,1,0,0));
        tbl.push_back(mk("cc_e1",   0,0,0,0,1, 1,0, 0,1,0,0));
        tbl.push_back(mk("clr_exp", 0,0,0,1,1, 1,0, 1,1,1,1));
        tbl.push_back(mk("cc_e3",   0,0,0,0,1, 1,0, 0,1,1,0));
        tbl.push_back(mk("st_exp",  0,1,0,0,1, 2,0, 2,1,0,0));
        tbl.push_back(mk("se_e1",   0,0,0,0,1, 2,0, 1,1,0,0));
        tbl.push_back(mk("se_e2",   0,0,0,1,1, 2,0, 0,1,0,0));
        tbl.push_back(mk("se_exp",  0,0,0,0,1, 2,0, 2,1,1,1));
        tbl.push_back(mk("rst_run", 1,0,0,0,1, 2,0, 0,0,0,0));
        tbl.push_back(mk("r5_e0",   0,1,0,0,0, 5,0, 5,1,0,0));
        tbl.push_back(mk("r5_e1",   0,0,0,0,0, 5,0, 4,1,0,0));
        tbl.push_back(mk("r5_rst1", 1,0,0,0,0, 5,0, 0,0,0,0));
        tbl.push_back(mk("r5_rst2", 1,0,0,0,0, 5,0, 0,0,0,0));
        tbl.push_back(mk("r5_idle", 0,0,0,0,0, 5,0, 0,0,0,0));
        tbl.push_back(mk("rx_e0",   0,1,0,0,1, 0,0, 0,1,0,0));
        tbl.push_back(mk("rst_exp", 1,0,0,0,1, 0,0, 0,0,0,0));
        tbl.push_back(mk("p0_e0",   0,1,0,0,1, 0,0, 0,1,0,0));
        tbl.push_back(mk("p0_e1",   0,0,0,0,1, 0,0, 0,1,1,1));
        tbl.push_back(mk("p0_e2",   0,0,0,0,1, 0,0, 0,1,1,1));
        tbl.push_back(mk("p0_e3",   0,0,0,0,1, 0,0, 0,1,1,1));
        tbl.push_back(mk("p0_stop", 0,0,1,0,1, 0,0, 0,0,1,0));
        tbl.push_back(mk("p0_clr",  0,0,0,1,1, 0,0, 0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].clear,
                  tbl[i].mode, tbl[i].period, tbl[i].presc);
            edge1();
            chk({tbl[i].name, ".count"}, 32'(count), 32'(tbl[i].e_count));
            chk({tbl[i].name, ".run"}, 32'(running), 32'(tbl[i].e_run));
            chk({tbl[i].name, ".tc"}, 32'(tc), 32'(tbl[i].e_tc));
            chk({tbl[i].name, ".tick"}, 32'(tick), 32'(tbl[i].e_tick));
        end

        // Prescaled periodic: P=1, Q=2 -> N=6.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 4'd2);
        edge1();
        chk("pre_e0.count", 32'(count), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'd2);
        for (int e = 1; e <= 19; e++) begin
            edge1();
            chk($sformatf("pre_e%0d.tick", e), 32'(tick),
                32'((e % 6) == 0));
            chk($sformatf("pre_e%0d.count", e), 32'(count),
                32'((e % 6) < 3));
            chk($sformatf("pre_e%0d.tc", e), 32'(tc), 32'(e >= 6));
        end

        // Stop and restart: P=9, stop sampled on edge 5 freezes count=5.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 4'd0);
        edge1();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd9, 4'd0);
        for (int e = 1; e <= 4; e++) begin
            edge1();
        end
        chk("sr_e4.count", 32'(count), 32'd5);
        stop = 1'b1;
        edge1();
        stop = 1'b0;
        chk("sr_stop.run", 32'(running), 32'd0);
        for (int e = 0; e < 10; e++) begin
            edge1();
            chk("sr_hold.count", 32'(count), 32'd5);
            chk("sr_hold.tick", 32'(tick), 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 4'd0);
        edge1();
        chk("sr_re.count", 32'(count), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 4'd0);
        edge1();
        chk("sr_re1.tick", 32'(tick), 32'd0);
        edge1();
        chk("sr_re2.tick", 32'(tick), 32'd0);
        edge1();
        chk("sr_re3.tick", 32'(tick), 32'd1);
        chk("sr_re3.tc", 32'(tc), 32'd1);

        // Full-range one-shot: P=255 expires after 256 edges.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255, 4'd0);
        edge1();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 4'd0);
        first = -1;
        for (int e = 1; e <= 300 && first < 0; e++) begin
            edge1();
            if (tick) first = e;
        end
        chk("wide.expiry_edge", 32'(first), 32'd256);
        chk("wide.run", 32'(running), 32'd0);
        extra = 0;
        for (int e = 0; e < 20; e++) begin
            edge1();
            if (tick) extra++;
        end
        chk("wide.no_more_ticks", 32'(extra), 32'd0);
        chk("wide.tc_sticky", 32'(tc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
